// File: rtl/alu_mdu_seq.sv
// Registered execute-stage ALU with valid/ready handshake and a multi-cycle multiply/divide unit (HI/LO).
// Optional macro ALU_OVF_EN adds a registered signed-overflow flag for add, sub and addi.
module alu_mdu_seq #(
    parameter int WIDTH    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      immediate,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             branch,
    output logic             busy
`ifdef ALU_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_BGEZ = 6'h01, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
    localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27, F_SLT = 6'h2a, F_MFHI = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   hi, lo;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   rem, dvsr, opnd, rem_nxt, quot_nxt, rs_hold;
    logic               neg_q, neg_r, div0;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_br, is_mul, is_div, is_sgn, accept, last;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic signed [WIDTH-1:0] imm_s, rs_s, rt_s;
    logic [WIDTH-1:0]        imm_z, sum_rt, dif_rt, sum_imm, br_off;

    assign imm_s   = WIDTH'($signed(immediate));
    assign imm_z   = WIDTH'(immediate);
    assign rs_s    = $signed(rs_val);
    assign rt_s    = $signed(rt_val);
    assign sum_rt  = rs_val + rt_val;
    assign dif_rt  = rs_val - rt_val;
    assign sum_imm = rs_val + imm_s;
    assign br_off  = imm_s <<< BR_SHIFT;

    // Decode and single-cycle result
    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        is_sgn  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_res = sum_rt;
                    F_SUB:   alu_res = dif_rt;
                    F_AND:   alu_res = rs_val & rt_val;
                    F_OR:    alu_res = rs_val | rt_val;
                    F_NOR:   alu_res = ~(rs_val | rt_val);
                    F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, (rs_s < rt_s)};
                    F_MFHI:  alu_res = hi;
                    F_MFLO:  alu_res = lo;
                    F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
                    F_MULTU: is_mul = 1'b1;
                    F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
                    F_DIVU:  is_div = 1'b1;
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI: alu_res = sum_imm;
            OP_SLTI: alu_res = {{(WIDTH-1){1'b0}}, (rs_s < imm_s)};
            OP_ANDI: alu_res = rs_val & imm_z;
            OP_ORI:  alu_res = rs_val | imm_z;
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: alu_res = sum_imm;
            OP_BEQ:  alu_br = (rs_val == rt_val);
            OP_BNE:  alu_br = (rs_val != rt_val);
            OP_BGEZ: alu_br = !rs_val[WIDTH-1];
            default: alu_res = '0;
        endcase
        if (alu_br) alu_res = br_off;
    end

`ifdef ALU_OVF_EN
    logic alu_ovf;
    always_comb begin
        alu_ovf = 1'b0;
        if (opcode == OP_RTYPE && funct == F_ADD)
            alu_ovf = (rs_val[WIDTH-1] == rt_val[WIDTH-1]) && (sum_rt[WIDTH-1] != rs_val[WIDTH-1]);
        else if (opcode == OP_RTYPE && funct == F_SUB)
            alu_ovf = (rs_val[WIDTH-1] != rt_val[WIDTH-1]) && (dif_rt[WIDTH-1] != rs_val[WIDTH-1]);
        else if (opcode == OP_ADDI)
            alu_ovf = (rs_val[WIDTH-1] == imm_s[WIDTH-1]) && (sum_imm[WIDTH-1] != rs_val[WIDTH-1]);
    end
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && is_mul)      state_nxt = MUL;
                else if (in_valid && is_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign accept = in_valid && in_ready;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Iteration step: shift-add multiply and restoring divide
    logic [WIDTH:0] shifted, trial;
    always_comb begin
        acc_nxt  = acc + (opnd[0] ? mcand : '0);
        shifted  = {rem, opnd[WIDTH-1]};
        trial    = shifted - {1'b0, dvsr};
        rem_nxt  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nxt = {opnd[WIDTH-2:0], !trial[WIDTH]};
    end

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin, rem_fin;

    assign neg_a    = is_sgn && rs_val[WIDTH-1];
    assign neg_b    = is_sgn && rt_val[WIDTH-1];
    assign mag_a    = neg_w(rs_val, neg_a);
    assign mag_b    = neg_w(rt_val, neg_b);
    assign prod_fin = neg_2w(acc_nxt, neg_q);
    assign quot_fin = div0 ? '1 : neg_w(quot_nxt, neg_q);
    assign rem_fin  = div0 ? rs_hold : neg_w(rem_nxt, neg_r);

    // Operand latch and iteration registers
    always_ff @(posedge clk) begin
        if (accept) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            rem     <= '0;
            dvsr    <= mag_b;
            opnd    <= is_mul ? mag_b : mag_a;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            div0    <= (rt_val == '0);
            rs_hold <= rs_val;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
            if (state == MUL) begin
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                opnd  <= opnd >> 1;
            end else begin
                rem  <= rem_nxt;
                opnd <= quot_nxt;
            end
        end
    end

    // Output and HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            branch    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
            if (accept && !is_mul && !is_div) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                branch    <= alu_br;
`ifdef ALU_OVF_EN
                ovf       <= alu_ovf;
`endif
            end else if (busy && last) begin
                out_valid <= 1'b1;
                branch    <= 1'b0;
                if (state == MUL) begin
                    hi     <= prod_fin[2*WIDTH-1:WIDTH];
                    lo     <= prod_fin[WIDTH-1:0];
                    result <= prod_fin[WIDTH-1:0];
                end else begin
                    hi     <= rem_fin;
                    lo     <= quot_fin;
                    result <= quot_fin;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Randomized self-checking bench for alu_mdu_seq against a plain-arithmetic reference model.
module tb_alu_mdu_seq;
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [15:0] immediate = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        branch;
    logic        busy;
`ifdef ALU_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    alu_mdu_seq #(.WIDTH(32), .BR_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val),
        .immediate(immediate), .out_valid(out_valid), .result(result),
        .branch(branch), .busy(busy)
`ifdef ALU_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: MIPS semantics in 64-bit arithmetic; updates the HI/LO model for mult/div.
    task automatic model_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [15:0] imm,
                            output bit mdu, output bit br, output logic [31:0] res, output bit o);
        longint a, b, s, q, r, si;
        logic [63:0] u;
        logic [31:0] sx, zx;
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        si = longint'($signed(sx));
        mdu = 0; br = 0; res = '0; o = 0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin s = a + b; res = s[31:0]; o = (s > MAXS) || (s < MINS); end
                6'h22: begin s = a - b; res = s[31:0]; o = (s > MAXS) || (s < MINS); end
                6'h24: res = rs & rt;
                6'h25: res = rs | rt;
                6'h27: res = ~(rs | rt);
                6'h2a: res = (a < b) ? 32'd1 : 32'd0;
                6'h10: res = hi_m;
                6'h12: res = lo_m;
                6'h18: begin mdu = 1; u = a * b; hi_m = u[63:32]; lo_m = u[31:0]; end
                6'h19: begin mdu = 1; u = {32'h0, rs} * {32'h0, rt}; hi_m = u[63:32]; lo_m = u[31:0]; end
                6'h1a: begin
                    mdu = 1;
                    if (rt == 0) begin lo_m = '1; hi_m = rs; end
                    else begin q = a / b; r = a % b; lo_m = q[31:0]; hi_m = r[31:0]; end
                end
                6'h1b: begin
                    mdu = 1;
                    if (rt == 0) begin lo_m = '1; hi_m = rs; end
                    else begin lo_m = rs / rt; hi_m = rs % rt; end
                end
                default: res = '0;
            endcase
            if (mdu) res = lo_m;
        end else begin
            case (op)
                6'h08: begin s = a + si; res = s[31:0]; o = (s > MAXS) || (s < MINS); end
                6'h0a: res = (a < si) ? 32'd1 : 32'd0;
                6'h0c: res = rs & zx;
                6'h0d: res = rs | zx;
                6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: res = rs + sx;
                6'h04: br = (rs == rt);
                6'h05: br = (rs != rt);
                6'h01: br = (a >= 0);
                default: res = '0;
            endcase
            if (br) res = sx * 4;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        bit mdu, br_e, o_e;
        logic [31:0] res_e;
        int n, busy_n;
        model_op(op, fn, rs, rt, imm, mdu, br_e, res_e, o_e);
        @(negedge clk);
        opcode = op; funct = fn; rs_val = rs; rt_val = rt; immediate = imm; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check({tag, "_accept"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && busy && !in_ready) busy_n++;
        end while (!out_valid && n < 100);
        check({tag, "_lat"}, 64'(n), mdu ? 64'd33 : 64'd1);
        check({tag, "_res"}, 64'(result), 64'(res_e));
        check({tag, "_br"}, 64'(branch), 64'(br_e));
        check({tag, "_busy"}, 64'(busy_n), mdu ? 64'd32 : 64'd0);
`ifdef ALU_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(o_e));
`endif
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    logic [5:0] r_fns [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h10, 6'h12,
                               6'h18, 6'h19, 6'h1a, 6'h1b, 6'h21};
    logic [5:0] i_ops [14] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h20, 6'h21, 6'h23, 6'h28,
                               6'h29, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h0f};

    initial begin
        logic [31:0] got_q[$];
        bit mdu, br_e, o_e, seen;
        logic [31:0] mul_e, add_e;
        logic [5:0] op, fn;
        logic [31:0] a, b;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ovld", 64'(out_valid), 64'd0);
        check("rst_res", 64'(result), 64'd0);
        check("rst_br", 64'(branch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd1);
        reset = 1'b0;

        run_op("add_wrap", 6'h00, 6'h20, 32'h7FFFFFFF, 32'h1, 16'h0);

        // beq then bne back to back
        @(negedge clk);
        opcode = 6'h04; funct = 6'h00; rs_val = 32'd5; rt_val = 32'd5; immediate = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 opcode = 6'h05;
        @(negedge clk);
        check("beq_vld", 64'(out_valid), 64'd1);
        check("beq_br", 64'(branch), 64'd1);
        check("beq_res", 64'(result), 64'hFFFFFFFC);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bne_vld", 64'(out_valid), 64'd1);
        check("bne_br", 64'(branch), 64'd0);
        check("bne_res", 64'(result), 64'd0);
        @(negedge clk);
        check("b2b_end", 64'(out_valid), 64'd0);

        run_op("mult", 6'h00, 6'h18, 32'hFFFFFFFD, 32'd7, 16'h0);
        run_op("mfhi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
        run_op("mflo", 6'h00, 6'h12, 32'h0, 32'h0, 16'h0);
        run_op("divu", 6'h00, 6'h1b, 32'd100, 32'd7, 16'h0);
        run_op("divu_hi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
        run_op("div_neg", 6'h00, 6'h1a, 32'hFFFFFFF9, 32'd2, 16'h0);
        run_op("div_neg_hi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
        run_op("divu_z", 6'h00, 6'h1b, 32'd9, 32'd0, 16'h0);
        run_op("divu_z_hi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
        run_op("div_min", 6'h00, 6'h1a, 32'h80000000, 32'hFFFFFFFF, 16'h0);
        run_op("div_min_hi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);
        run_op("div_z_s", 6'h00, 6'h1a, 32'hFFFFFFF0, 32'd0, 16'h0);
        run_op("div_z_s_hi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);

        // reset in the middle of a divide
        @(negedge clk);
        opcode = 6'h00; funct = 6'h1a; rs_val = 32'd1000; rt_val = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        repeat (9) begin @(negedge clk); seen |= out_valid; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen |= out_valid;
        check("rstmid_rdy", 64'(in_ready), 64'd1);
        check("rstmid_busy", 64'(busy), 64'd0);
        repeat (40) begin @(negedge clk); seen |= out_valid; end
        check("rstmid_novld", 64'(seen), 64'd0);
        hi_m = '0;
        lo_m = '0;
        run_op("rstmid_mfhi", 6'h00, 6'h10, 32'h0, 32'h0, 16'h0);

        // addi held while multiplier busy: accepted once after return to IDLE
        model_op(6'h00, 6'h19, 32'd123456, 32'd98765, 16'h0, mdu, br_e, mul_e, o_e);
        model_op(6'h08, 6'h00, 32'd1000, 32'h0, 16'hFFF6, mdu, br_e, add_e, o_e);
        @(negedge clk);
        opcode = 6'h00; funct = 6'h19; rs_val = 32'd123456; rt_val = 32'd98765; in_valid = 1'b1;
        @(posedge clk);
        #1 opcode = 6'h08; rs_val = 32'd1000; rt_val = 32'hDEADBEEF; immediate = 16'hFFF6;
        n = 0;
        while (n < 80) begin
            @(negedge clk);
            n++;
            if (out_valid) got_q.push_back(result);
            if (in_valid && in_ready) begin @(posedge clk); #1 in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        check("hold_cnt", 64'(got_q.size()), 64'd2);
        if (got_q.size() >= 2) begin
            check("hold_mul", 64'(got_q[0]), 64'(mul_e));
            check("hold_addi", 64'(got_q[1]), 64'(add_e));
        end

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 99) < 50) begin
                op = 6'h00;
                fn = r_fns[$urandom_range(0, 12)];
            end else begin
                op = i_ops[$urandom_range(0, 13)];
                fn = 6'($urandom);
            end
            a = pick_val();
            b = ($urandom_range(0, 3) == 0) ? a : pick_val();
            run_op($sformatf("rnd%0d", i), op, fn, a, b, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised, registered successor to the single-cycle execute ALU in the MIPS_32 core. Adds a valid/ready operand handshake, one-cycle registered results for all existing R/I-type, branch and load/store-address ops, and a multi-cycle multiply/divide unit with HI/LO registers (mult, multu, div, divu, mfhi, mflo). Sits in the execute stage between register read and writeback/PC-select.

Parameters:
WIDTH, 32, datapath width in bits; legal range 16..64. Immediates are sign- or zero-extended to WIDTH.
BR_SHIFT, 2, left shift applied to the sign-extended branch immediate to form the branch offset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and opcode valid this cycle
in_ready  output  1  unit can accept an op this cycle
opcode  input  6  instruction opcode field
funct  input  6  R-type funct field
rs_val  input  WIDTH  rs operand
rt_val  input  WIDTH  rt operand
immediate  input  16  I-type immediate
out_valid  output  1  one-cycle pulse: result/branch valid
result  output  WIDTH  op result, address or branch offset
branch  output  1  branch taken; qualified by out_valid
busy  output  1  multiply/divide in progress

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset values: out_valid=0, result=0, branch=0, busy=0, in_ready=1, HI=0, LO=0, FSM=IDLE.
- Reset asserted mid-multiply or mid-divide abandons the op with no out_valid pulse, and clears HI/LO.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready=1 only in IDLE. An op is accepted on a clock edge where in_valid&&in_ready.
- Single-cycle ops, accepted at edge k: result and branch are registered; out_valid=1 for the cycle after edge k. Back-to-back accepts are allowed, one per cycle.
- Single-cycle op set:
  - R-type: add, sub, and, or, nor, slt (signed), mfhi (funct 010000), mflo (funct 010010).
  - I-type: addi, slti (sign-extended immediate); andi, ori (zero-extended immediate).
  - Loads/stores lb, lh, lw, sb, sh, sw: result = rs + sext(imm).
- Branches: beq, bne, and bgez (opcode 000001, rs signed >= 0).
  - Taken: branch=1, result = sext(imm) << BR_SHIFT.
  - Not taken: branch=0, result=0.
- Unknown opcode or funct: out_valid still pulses, result=0, branch=0.
- Add/sub wrap modulo 2^WIDTH; no trap unless ALU_OVF_EN is defined.
- Multiply (mult 011000, multu 011001):
  - IDLE -> MUL; busy=1.
  - Shift-add, one bit per cycle, WIDTH iterations.
  - Signed variant uses operand magnitudes with a final sign fix.
  - Then DONE: {HI,LO} = full 2*WIDTH-bit product, out_valid=1 with result=LO; back to IDLE next cycle.
  - out_valid occurs exactly WIDTH+1 cycles after the accept edge.
- Divide (div 011010, divu 011011):
  - Restoring algorithm, WIDTH iterations, same timing as multiply.
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = all ones, HI = rs_val; same latency.
  - Signed most-negative / -1: LO = most-negative value, HI = 0.
- mfhi/mflo are accepted only in IDLE, so they always observe completed HI/LO.
- Inputs are ignored while in_ready=0. Operands are latched at accept; later changes to the inputs have no effect.

Optional Feature:
Macro ALU_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), registered alongside out_valid.
  - ovf=1 on signed overflow of add, sub or addi.
  - result still carries the wrapped sum.
  - ovf=0 for all other ops.
- Undefined: port absent; no overflow detection logic.

Test Plan:
1. WIDTH=32; reset then add with rs=0x7FFFFFFF, rt=1 -> out_valid one cycle after accept, result=0x80000000; ovf=1 when ALU_OVF_EN is defined.
2. beq rs=rt=5, imm=0xFFFF -> branch=1, result=0xFFFFFFFC. Then bne with the same operands -> branch=0, result=0. Two consecutive accepts give two consecutive out_valid pulses.
3. mult rs=0xFFFFFFFD (-3), rt=7 -> busy=1 and in_ready=0 for 32 cycles, out_valid at cycle 33, result=0xFFFFFFEB. Then mfhi -> 0xFFFFFFFF; mflo -> 0xFFFFFFEB.
4. divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 9/0 -> LO=0xFFFFFFFF, HI=9.
5. Start div, assert reset at cycle 10 -> no out_valid pulse, in_ready=1 next cycle, mfhi returns 0.
6. Hold in_valid with an addi during busy -> not accepted until IDLE, then accepted exactly once, with result = rs + sext(imm).
